// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding and SPI mode constants for the SPI slave
package spi_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;
  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser plus rise/fall detect against a third flop
// Ports: clk, rst (async active-high), d async input, q synchronised level, rise/fall one-clk edge pulses
module spi_sync_edge #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= {3{RST_VAL}};
    else s <= {s[1:0], d};
  assign q    = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave with configurable CPOL/CPHA, tx holding register and received-word output
// Ports: clk, rst (async active-high); sclk, cs_n, mosi asynchronous SPI inputs; miso/miso_oe serial output;
//   tx_data/tx_valid/tx_ready holding-register load; rx_data/rx_valid received word; tx_underrun; busy
module spi_slave
  import spi_pkg::*;
#(
  parameter bit CPOL       = 1'b1,
  parameter bit CPHA       = 1'b0,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  state_t state, state_d;
  logic [CW-1:0] bit_cnt;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_word, tx_shift, hold;
  logic hold_full, pre_full;
  logic sclk_q, sclk_rise, sclk_fall, cs_q, cs_rise, cs_fall, mosi_q, mosi_rise, mosi_fall;
  logic lead, trail, act, smp, wrap, cnt_zero, first_lead, src_full, consume, accept, load_en, shift_en;
  logic unused_edges;
  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );
  assign unused_edges = sclk_q ^ mosi_rise ^ mosi_fall;
  assign lead       = CPOL ? sclk_fall : sclk_rise;
  assign trail      = CPOL ? sclk_rise : sclk_fall;
  assign act        = state == ACTIVE;
  assign smp        = act & (CPHA ? trail : lead);
  assign wrap       = bit_cnt == CW'(DATA_WIDTH - 1);
  assign cnt_zero   = bit_cnt == '0;
  assign first_lead = act & lead & cnt_zero;
  assign rx_word    = {rx_shift, mosi_q};
  // CPHA=0 must preload before the first leading edge, so the consume/underrun decision
  // is deferred to that edge; a preload after the last word of a frame then costs nothing
  assign src_full   = CPHA ? hold_full : pre_full;
  assign consume    = first_lead & src_full;
  assign accept     = tx_valid & ~hold_full;
  assign load_en    = CPHA ? first_lead : ((state == IDLE) & cs_fall) | (act & trail & cnt_zero);
  assign shift_en   = act & (CPHA ? lead : trail) & ~cnt_zero;
  assign tx_ready   = ~hold_full;
  assign miso_oe    = ~cs_q;
  assign miso       = miso_oe & tx_shift[DATA_WIDTH-1];
  assign busy       = act;
  always_comb begin
    state_d = state;
    if (state == IDLE && cs_fall) state_d = ACTIVE;
    else if (act && cs_rise) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      hold        <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      pre_full    <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= (!act || cs_rise) ? '0 : smp ? (wrap ? '0 : bit_cnt + 1'b1) : bit_cnt;
      if (smp) rx_shift <= rx_word[DATA_WIDTH-2:0];
      if (smp && wrap) rx_data <= rx_word;
      rx_valid    <= smp & wrap;
      tx_underrun <= first_lead & ~src_full;
      if (accept) hold <= tx_data;
      hold_full   <= accept | (hold_full & ~consume);
      if (load_en) tx_shift <= hold_full ? hold : '0;
      else if (shift_en) tx_shift <= tx_shift << 1;
      pre_full    <= !cs_rise && (load_en ? hold_full : pre_full);
    end
endmodule
